data_mem_access: RTL and testbench

// Data-memory access sequencer between the execute stage and the data bus, directly upstream of load_unit.

---
 rtl/data_mem_access.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_access.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access.sv
// data_mem_access: load/store sequencer between execute and the data bus.
// Captures one request, runs a single valid/ready bus transaction, builds
// byte strobes and replicated write data, and right-aligns read data for
// load_unit. BUSY stalls the pipeline while a transaction is outstanding.
// Optional build macro: MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of silently ignoring the low address bits).
module data_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        IS_STORE,
  input  logic [1:0]  MEM_SIZE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] STORE_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic        MISALIGNED,
  output logic [31:0] LOAD_DATA,
  output logic        BUS_VALID,
  input  logic        BUS_READY,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_RVALID,
  input  logic [31:0] BUS_RDATA
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FIN} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit LP_TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [31:0] r_load_data;
  logic        r_bus_valid;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_wdata;
  logic        r_is_store;
  logic [1:0]  r_off;
  logic [CW-1:0] r_cnt;

  logic [1:0]  w_off;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic        w_tmo_hit;

`ifdef MISALIGN_TRAP_EN
  logic r_misal;
  logic w_misal;

  // Half needs an even address, word needs a 4-byte aligned address
  always_comb begin
    w_misal = 1'b0;
    case (MEM_SIZE)
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = ADDRESS[0];
      default: w_misal = |ADDRESS[1:0];
    endcase
  end

  assign MISALIGNED = r_misal;
`else
  assign MISALIGNED = 1'b0;
`endif

  // Lane offset, byte strobes and replicated write data from the raw request
  always_comb begin
    w_off   = ADDRESS[1:0];
    w_wstrb = '0;
    w_wdata = STORE_DATA;
    case (MEM_SIZE)
      2'b00: begin
        w_off   = ADDRESS[1:0];
        w_wstrb = 4'b0001 << w_off;
        w_wdata = {4{STORE_DATA[7:0]}};
      end
      2'b01: begin
        w_off   = {ADDRESS[1], 1'b0};
        w_wstrb = 4'b0011 << w_off;
        w_wdata = {2{STORE_DATA[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_wstrb = 4'b1111;
        w_wdata = STORE_DATA;
      end
    endcase
    if (!IS_STORE) begin
      w_wstrb = '0;
    end
  end

  assign w_tmo_hit = LP_TMO_EN && (r_cnt == LP_CNT_LAST);

  // Request/response sequencer with registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_load_data <= '0;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wstrb <= '0;
      r_bus_wdata <= '0;
      r_is_store  <= 1'b0;
      r_off       <= '0;
      r_cnt       <= '0;
`ifdef MISALIGN_TRAP_EN
      r_misal     <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_misal <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_is_store  <= IS_STORE;
            r_off       <= w_off;
            r_bus_addr  <= {ADDRESS[31:2], 2'b00};
            r_bus_we    <= IS_STORE;
            r_bus_wstrb <= w_wstrb;
            r_bus_wdata <= w_wdata;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
`ifdef MISALIGN_TRAP_EN
            if (w_misal) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_misal <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_bus_valid <= 1'b1;
            end
`else
            r_state     <= S_REQ;
            r_bus_valid <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (r_bus_valid && BUS_READY) begin
            r_bus_valid <= 1'b0;
            r_cnt       <= '0;
            if (r_is_store) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RESP;
            end
          end else if (w_tmo_hit) begin
            r_bus_valid <= 1'b0;
            r_load_data <= '0;
            r_state     <= S_FIN;
            r_done      <= 1'b1;
            r_error     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (BUS_RVALID) begin
            r_load_data <= BUS_RDATA >> {r_off, 3'b000};
            r_state     <= S_FIN;
            r_done      <= 1'b1;
          end else if (w_tmo_hit) begin
            r_load_data <= '0;
            r_state     <= S_FIN;
            r_done      <= 1'b1;
            r_error     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERROR     = r_error;
  assign LOAD_DATA = r_load_data;
  assign BUS_VALID = r_bus_valid;
  assign BUS_WE    = r_bus_we;
  assign BUS_ADDR  = r_bus_addr;
  assign BUS_WSTRB = r_bus_wstrb;
  assign BUS_WDATA = r_bus_wdata;

endmodule

// File: tb/tb_data_mem_access.sv
// Testbench for data_mem_access (default build, TIMEOUT_CYCLES=4).
module tb_data_mem_access;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        IS_STORE;
  logic [1:0]  MEM_SIZE;
  logic [31:0] ADDRESS;
  logic [31:0] STORE_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic        MISALIGNED;
  logic [31:0] LOAD_DATA;
  logic        BUS_VALID;
  logic        BUS_READY;
  logic        BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [3:0]  BUS_WSTRB;
  logic [31:0] BUS_WDATA;
  logic        BUS_RVALID;
  logic [31:0] BUS_RDATA;

  data_mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .IS_STORE   (IS_STORE),
    .MEM_SIZE   (MEM_SIZE),
    .ADDRESS    (ADDRESS),
    .STORE_DATA (STORE_DATA),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .MISALIGNED (MISALIGNED),
    .LOAD_DATA  (LOAD_DATA),
    .BUS_VALID  (BUS_VALID),
    .BUS_READY  (BUS_READY),
    .BUS_WE     (BUS_WE),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_WSTRB  (BUS_WSTRB),
    .BUS_WDATA  (BUS_WDATA),
    .BUS_RVALID (BUS_RVALID),
    .BUS_RDATA  (BUS_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } beat_t;

  // rdy: cycles READY is withheld after VALID (-1 = never)
  // rvd: cycles RVALID is withheld in RESP (-1 = never)
  // e_done: cycle DONE is expected, START driven in cycle 0
  typedef struct {
    string       name;
    bit          st;
    bit [1:0]    sz;
    bit [31:0]   addr;
    bit [31:0]   sdata;
    bit [31:0]   rdata;
    int          rdy;
    int          rvd;
    bit          pulse;
    bit [31:0]   e_addr;
    bit [3:0]    e_wstrb;
    bit [31:0]   e_wdata;
    int          e_done;
    bit [31:0]   e_ld;
    bit          e_err;
  } vec_t;

  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  beat_t       exp_q[$];
  vec_t        vecs[14];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  // Bus-side scoreboard: request fields must match the queued beat every VALID cycle
  always @(negedge CLK) begin
    if (!RESET && BUS_VALID) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_request", 32'(BUS_ADDR), 32'hFFFF_FFFF);
      end else begin
        chk("bus_addr",  BUS_ADDR, exp_q[0].addr);
        chk("bus_we",    32'(BUS_WE), 32'(exp_q[0].we));
        chk("bus_wstrb", 32'(BUS_WSTRB), 32'(exp_q[0].wstrb));
        if (exp_q[0].we) chk("bus_wdata", BUS_WDATA, exp_q[0].wdata);
        if (BUS_READY) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run(input vec_t v);
    beat_t b;
    int c, vc, rc, dc;
    bit hs, hs_now, got;
    @(posedge CLK); #1;
    START = 1'b1; IS_STORE = v.st; MEM_SIZE = v.sz;
    ADDRESS = v.addr; STORE_DATA = v.sdata;
    BUS_READY = 1'b0; BUS_RVALID = 1'b1; BUS_RDATA = JUNK;
    b.addr = v.e_addr; b.we = v.st; b.wstrb = v.e_wstrb; b.wdata = v.e_wdata;
    exp_q.push_back(b);
    @(negedge CLK);
    chk({v.name, ".busy_c0"}, 32'(BUSY), 32'd0);
    c = 1; vc = 0; rc = 0; hs = 0; hs_now = 0; got = 0; dc = -1;
    while (!got && c < 40) begin
      @(posedge CLK); #1;
      if (hs_now) hs = 1;
      // request inputs scrambled after capture; optional re-pulse of START
      START = v.pulse && (c <= 2);
      IS_STORE = ~v.st; MEM_SIZE = ~v.sz;
      ADDRESS = 32'h0000_0099 ^ v.addr; STORE_DATA = ~v.sdata;
      BUS_READY = 1'b0;
      if (BUS_VALID && !hs) begin
        vc++;
        BUS_READY = (v.rdy >= 0) && (vc > v.rdy);
      end
      if (hs && !v.st) begin
        rc++;
        BUS_RVALID = (v.rvd >= 0) && (rc > v.rvd);
        BUS_RDATA  = BUS_RVALID ? v.rdata : JUNK;
      end else begin
        BUS_RVALID = 1'b1;
        BUS_RDATA  = JUNK;
      end
      @(negedge CLK);
      hs_now = BUS_VALID && BUS_READY;
      if (c == 1) chk({v.name, ".busy_c1"}, 32'(BUSY), 32'd1);
      if (DONE) begin
        got = 1; dc = c;
      end else begin
        c++;
      end
    end
    chk({v.name, ".done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({v.name, ".done_cycle"}, 32'(dc), 32'(v.e_done));
      chk({v.name, ".error"}, 32'(ERROR), 32'(v.e_err));
      chk({v.name, ".misaligned"}, 32'(MISALIGNED), 32'd0);
      chk({v.name, ".load_data"}, LOAD_DATA, v.e_ld);
    end
    @(posedge CLK); #1;
    START = 1'b0; BUS_READY = 1'b0; BUS_RVALID = 1'b0;
    @(negedge CLK);
    chk({v.name, ".done_pulse"}, 32'(DONE), 32'd0);
    chk({v.name, ".busy_after"}, 32'(BUSY), 32'd0);
    chk({v.name, ".load_hold"}, LOAD_DATA, v.e_ld);
    if (v.rdy < 0) begin
      chk({v.name, ".req_unaccepted"}, 32'(exp_q.size()), 32'd1);
      exp_q.delete();
    end
    chk({v.name, ".one_handshake"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name              st  sz     addr          sdata         rdata         rdy rvd pl e_addr        wstrb    e_wdata       dn e_ld          err
    vecs[0]  = '{"lb_off3",        0, 2'b00, 32'h0000_1003, 32'h0,        32'hAABBCCDD,  0,  0, 0, 32'h0000_1000, 4'b0000, 32'h0,        3, 32'h0000_00AA, 0};
    vecs[1]  = '{"sh_wait2",       1, 2'b01, 32'h0000_2002, 32'h1234ABCD, 32'h0,         2,  0, 0, 32'h0000_2000, 4'b1100, 32'hABCDABCD, 4, 32'h0000_00AA, 0};
    vecs[2]  = '{"sb_busy_start",  1, 2'b00, 32'h0000_0031, 32'h0000_005A, 32'h0,        0,  0, 1, 32'h0000_0030, 4'b0010, 32'h5A5A5A5A, 2, 32'h0000_00AA, 0};
    vecs[3]  = '{"lh_rv2",         0, 2'b01, 32'h0000_1002, 32'h0,        32'hAABBCCDD,  1,  2, 0, 32'h0000_1000, 4'b0000, 32'h0,        6, 32'h0000_AABB, 0};
    vecs[4]  = '{"lw_low_ignored", 0, 2'b10, 32'h0000_1002, 32'h0,        32'h11223344,  0,  0, 0, 32'h0000_1000, 4'b0000, 32'h0,        3, 32'h1122_3344, 0};
    vecs[5]  = '{"sw_addr7",       1, 2'b10, 32'h0000_4007, 32'hCAFEF00D, 32'h0,         0,  0, 0, 32'h0000_4004, 4'b1111, 32'hCAFEF00D, 2, 32'h1122_3344, 0};
    vecs[6]  = '{"sh_odd",         1, 2'b01, 32'h0000_5001, 32'h0000_BEEF, 32'h0,        0,  0, 0, 32'h0000_5000, 4'b0011, 32'hBEEFBEEF, 2, 32'h1122_3344, 0};
    vecs[7]  = '{"size11_word",    1, 2'b11, 32'h0000_0008, 32'h87654321, 32'h0,         0,  0, 0, 32'h0000_0008, 4'b1111, 32'h87654321, 2, 32'h1122_3344, 0};
    vecs[8]  = '{"lb_off1",        0, 2'b00, 32'h0000_7001, 32'h0,        32'h12345678,  0,  0, 0, 32'h0000_7000, 4'b0000, 32'h0,        3, 32'h0012_3456, 0};
    vecs[9]  = '{"resp_timeout",   0, 2'b10, 32'h0000_0100, 32'h0,        32'h0,         0, -1, 0, 32'h0000_0100, 4'b0000, 32'h0,        6, 32'h0000_0000, 1};
    vecs[10] = '{"resp_edge",      0, 2'b01, 32'h0000_0103, 32'h0,        32'hFFEE8899,  0,  3, 0, 32'h0000_0100, 4'b0000, 32'h0,        6, 32'h0000_FFEE, 0};
    vecs[11] = '{"req_edge",       1, 2'b00, 32'h0000_0203, 32'h0000_0077, 32'h0,        3,  0, 0, 32'h0000_0200, 4'b1000, 32'h77777777, 5, 32'h0000_FFEE, 0};
    vecs[12] = '{"req_timeout",    1, 2'b10, 32'h0000_0300, 32'hAAAA5555, 32'h0,        -1,  0, 0, 32'h0000_0300, 4'b1111, 32'hAAAA5555, 5, 32'h0000_0000, 1};
    vecs[13] = '{"lb_recover",     0, 2'b00, 32'h0000_0002, 32'h0,        32'h00C30000,  0,  0, 0, 32'h0000_0000, 4'b0000, 32'h0,        3, 32'h0000_00C3, 0};

    RESET = 1'b1; START = 1'b0; IS_STORE = 1'b0; MEM_SIZE = 2'b00;
    ADDRESS = '0; STORE_DATA = '0; BUS_READY = 1'b0; BUS_RVALID = 1'b0; BUS_RDATA = '0;
    repeat (2) @(negedge CLK);
    chk("rst.busy",       32'(BUSY), 32'd0);
    chk("rst.done",       32'(DONE), 32'd0);
    chk("rst.error",      32'(ERROR), 32'd0);
    chk("rst.misaligned", 32'(MISALIGNED), 32'd0);
    chk("rst.load_data",  LOAD_DATA, 32'd0);
    chk("rst.bus_valid",  32'(BUS_VALID), 32'd0);
    chk("rst.bus_we",     32'(BUS_WE), 32'd0);
    chk("rst.bus_addr",   BUS_ADDR, 32'd0);
    chk("rst.bus_wstrb",  32'(BUS_WSTRB), 32'd0);
    chk("rst.bus_wdata",  BUS_WDATA, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    for (int i = 0; i < 14; i++) run(vecs[i]);

    // Reset asserted while a load waits in REQ; LOAD_DATA holds 0xC3 beforehand
    begin
      beat_t b;
      @(posedge CLK); #1;
      START = 1'b1; IS_STORE = 1'b0; MEM_SIZE = 2'b10; ADDRESS = 32'h0000_0804;
      b.addr = 32'h0000_0804; b.we = 1'b0; b.wstrb = 4'b0000; b.wdata = '0;
      exp_q.push_back(b);
      @(posedge CLK); #1;
      START = 1'b0;
      @(negedge CLK);
      chk("mid_rst.valid_before", 32'(BUS_VALID), 32'd1);
      @(posedge CLK); #1;
      RESET = 1'b1;
      #1;
      chk("mid_rst.bus_valid", 32'(BUS_VALID), 32'd0);
      chk("mid_rst.busy",      32'(BUSY), 32'd0);
      chk("mid_rst.load_data", LOAD_DATA, 32'd0);
      @(negedge CLK);
      @(posedge CLK); #1;
      RESET = 1'b0;
      exp_q.delete();
    end
    run(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
